// File: rtl/cache_data_mem_ctrl.sv
// Front-end for the single-port cache line memory: arbitrates DDR line fills against
// line reads and streams registered read data out through a small FIFO.
module cache_data_mem_ctrl #(
  parameter int LINE_BITS    = 384,
  parameter int ADDR_WDTH    = 7,
  parameter int OBUF_DEPTH   = 2,
  parameter int MAX_FILL_RUN = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fill_valid_in,
  input  logic [ADDR_WDTH-1:0] fill_addr_in,
  input  logic [LINE_BITS-1:0] fill_data_in,
  output logic                 fill_ready_out,
  input  logic                 rd_valid_in,
  input  logic [ADDR_WDTH-1:0] rd_addr_in,
  output logic                 rd_ready_out,
  output logic                 rd_data_valid_out,
  output logic [LINE_BITS-1:0] rd_data_out,
  input  logic                 rd_data_ready_in,
  output logic [ADDR_WDTH-1:0] mem_addr_out,
  output logic [LINE_BITS-1:0] mem_w_data_out,
  output logic                 mem_w_en_out,
  input  logic [LINE_BITS-1:0] mem_r_data_in
);

  localparam int CNT_W = $clog2(OBUF_DEPTH + 1);
  localparam int PTR_W = $clog2(OBUF_DEPTH);
  localparam int RUN_W = $clog2(MAX_FILL_RUN + 1);

  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [RUN_W-1:0]     fill_run_q, fill_run_d;
  logic                 rd_inflight_q;
  logic [LINE_BITS-1:0] obuf_q [OBUF_DEPTH];

  logic             pop;
  logic             push;
  logic [CNT_W:0]   reserved;
  logic             rd_ok;
  logic             fill_pick;
  logic             grant_fill;
  logic             grant_rd;

  assign pop  = (count_q != '0) && rd_data_ready_in;
  assign push = rd_inflight_q;

  // Space is reserved at issue time so the registered read data always has a slot.
  assign reserved = {1'b0, count_q} + (CNT_W + 1)'(rd_inflight_q) - (CNT_W + 1)'(pop);
  assign rd_ok    = rd_valid_in && (reserved < (CNT_W + 1)'(OBUF_DEPTH));

  assign fill_pick  = fill_valid_in && !(rd_ok && (fill_run_q == RUN_W'(MAX_FILL_RUN)));
  assign grant_fill = rst_n && fill_pick;
  assign grant_rd   = rst_n && !fill_pick && rd_ok;

  assign fill_ready_out = grant_fill;
  assign rd_ready_out   = grant_rd;
  assign mem_w_en_out   = grant_fill;
  assign mem_w_data_out = grant_fill ? fill_data_in : '0;
  assign mem_addr_out   = grant_fill ? fill_addr_in :
                          grant_rd   ? rd_addr_in   : '0;

  assign rd_data_valid_out = (count_q != '0);
  assign rd_data_out       = obuf_q[rd_ptr_q];

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_run_d = fill_run_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
    // The starvation counter only measures fills that overtake a waiting read.
    if (!rd_valid_in || grant_rd)
      fill_run_d = '0;
    else if (grant_fill && (fill_run_q != RUN_W'(MAX_FILL_RUN)))
      fill_run_d = fill_run_q + RUN_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fill_run_q    <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_run_q    <= fill_run_d;
      rd_inflight_q <= grant_rd;
    end
  end

  // Data storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) obuf_q[wr_ptr_q] <= mem_r_data_in;
  end

endmodule

// File: tb/tb_cache_data_mem_ctrl.sv
// Directed bench for cache_data_mem_ctrl with a behavioural single-port line memory.
module tb_cache_data_mem_ctrl;

  localparam int LB = 384;
  localparam int AW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fill_valid_in = 1'b0;
  logic [AW-1:0] fill_addr_in = '0;
  logic [LB-1:0] fill_data_in = '0;
  logic          fill_ready_out;
  logic          rd_valid_in = 1'b0;
  logic [AW-1:0] rd_addr_in = '0;
  logic          rd_ready_out;
  logic          rd_data_valid_out;
  logic [LB-1:0] rd_data_out;
  logic          rd_data_ready_in = 1'b0;
  logic [AW-1:0] mem_addr_out;
  logic [LB-1:0] mem_w_data_out;
  logic          mem_w_en_out;
  logic [LB-1:0] mem_r_data_in;

  logic [LB-1:0] mem [128];
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cache_data_mem_ctrl #(
    .LINE_BITS(LB), .ADDR_WDTH(AW), .OBUF_DEPTH(2), .MAX_FILL_RUN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .fill_valid_in(fill_valid_in), .fill_addr_in(fill_addr_in),
    .fill_data_in(fill_data_in), .fill_ready_out(fill_ready_out),
    .rd_valid_in(rd_valid_in), .rd_addr_in(rd_addr_in), .rd_ready_out(rd_ready_out),
    .rd_data_valid_out(rd_data_valid_out), .rd_data_out(rd_data_out),
    .rd_data_ready_in(rd_data_ready_in),
    .mem_addr_out(mem_addr_out), .mem_w_data_out(mem_w_data_out),
    .mem_w_en_out(mem_w_en_out), .mem_r_data_in(mem_r_data_in)
  );

  // Single-port memory with registered read data; a write cycle reads old contents.
  always @(posedge clk) begin
    if (mem_w_en_out) mem[mem_addr_out] <= mem_w_data_out;
    mem_r_data_in <= mem[mem_addr_out];
  end

  function automatic logic [LB-1:0] pat(input logic [7:0] b);
    return {48{b}};
  endfunction

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fill(input logic [AW-1:0] a, input logic [LB-1:0] d);
    fill_valid_in = 1'b1; fill_addr_in = a; fill_data_in = d;
    #2;
    chk("fill_grant", LB'(fill_ready_out), LB'(1));
    chk("fill_addr", LB'(mem_addr_out), LB'(a));
    $display("fill addr %0d granted=%0b", a, fill_ready_out);
    tick();
    fill_valid_in = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] addrs [4];
    logic [7:0]    bytes [4];
    logic [9:0]    fill_pat;

    for (int i = 0; i < 128; i++) mem[i] = '0;

    // Reset: grants forced low even with a pending fill
    #1;
    fill_valid_in = 1'b1; fill_addr_in = 7'd3;
    #2;
    chk("reset_fill_ready", LB'(fill_ready_out), LB'(0));
    chk("reset_w_en", LB'(mem_w_en_out), LB'(0));
    chk("reset_valid", LB'(rd_data_valid_out), LB'(0));
    fill_valid_in = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Fill/read latency on address 5
    do_fill(7'd5, pat(8'hA5));
    rd_valid_in = 1'b1; rd_addr_in = 7'd5; rd_data_ready_in = 1'b1;
    #2;
    chk("rd_grant", LB'(rd_ready_out), LB'(1));
    chk("rd_w_en", LB'(mem_w_en_out), LB'(0));
    chk("rd_addr", LB'(mem_addr_out), LB'(5));
    tick();
    rd_valid_in = 1'b0;
    #2 chk("lat_t1_valid", LB'(rd_data_valid_out), LB'(0));
    chk("idle_addr", LB'(mem_addr_out), LB'(0));
    tick();
    chk("lat_t2_valid", LB'(rd_data_valid_out), LB'(1));
    chk("lat_t2_data", rd_data_out, pat(8'hA5));
    $display("read addr 5 data %0h", rd_data_out[7:0]);
    tick();
    chk("lat_pop_valid", LB'(rd_data_valid_out), LB'(0));
    rd_data_ready_in = 1'b0;

    do_fill(7'd1, pat(8'h01));
    do_fill(7'd2, pat(8'h02));
    do_fill(7'd3, pat(8'h03));
    do_fill(7'd9, pat(8'h11));

    // Back-pressure: only two reads fit while the consumer stalls
    rd_valid_in = 1'b1; rd_addr_in = 7'd1;
    #2 chk("bp_rd1", LB'(rd_ready_out), LB'(1));
    tick();
    rd_addr_in = 7'd2;
    #2 chk("bp_rd2", LB'(rd_ready_out), LB'(1));
    tick();
    rd_addr_in = 7'd3;
    #2 chk("bp_rd3_stall", LB'(rd_ready_out), LB'(0));
    tick();
    #2 chk("bp_rd3_stall2", LB'(rd_ready_out), LB'(0));
    chk("bp_head_valid", LB'(rd_data_valid_out), LB'(1));
    chk("bp_head1", rd_data_out, pat(8'h01));
    rd_data_ready_in = 1'b1;
    #1 chk("bp_rd3_on_pop", LB'(rd_ready_out), LB'(1));
    $display("backpressure: read 3 accepted on pop = %0b", rd_ready_out);
    tick();
    rd_valid_in = 1'b0;
    chk("bp_head2", rd_data_out, pat(8'h02));
    tick();
    chk("bp_head3", rd_data_out, pat(8'h03));
    tick();
    chk("bp_empty", LB'(rd_data_valid_out), LB'(0));

    // Fairness: continuous fill+read gives 4 fills then 1 read
    fill_pat = 10'b1111011110;
    fill_valid_in = 1'b1; fill_addr_in = 7'd20; fill_data_in = pat(8'h20);
    rd_valid_in = 1'b1; rd_addr_in = 7'd20;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk("fair_fill", LB'(fill_ready_out), LB'(fill_pat[9-i]));
      chk("fair_rd", LB'(rd_ready_out), LB'(!fill_pat[9-i]));
      $display("fair cycle %0d fill=%0b rd=%0b", i, fill_ready_out, rd_ready_out);
      tick();
    end
    fill_valid_in = 1'b0; rd_valid_in = 1'b0;
    tick(); tick(); tick();
    chk("fair_drained", LB'(rd_data_valid_out), LB'(0));

    // Same-cycle fill and read to address 9: fill first, read sees new data
    fill_valid_in = 1'b1; fill_addr_in = 7'd9; fill_data_in = pat(8'h22);
    rd_valid_in = 1'b1; rd_addr_in = 7'd9;
    #2;
    chk("haz_fill_first", LB'(fill_ready_out), LB'(1));
    chk("haz_rd_held", LB'(rd_ready_out), LB'(0));
    tick();
    fill_valid_in = 1'b0;
    #2 chk("haz_rd_next", LB'(rd_ready_out), LB'(1));
    tick();
    rd_valid_in = 1'b0;
    tick();
    chk("haz_valid", LB'(rd_data_valid_out), LB'(1));
    chk("haz_data", rd_data_out, pat(8'h22));
    $display("hazard read addr 9 data %0h", rd_data_out[7:0]);
    tick();

    // Back-to-back reads with continuous pop
    addrs[0] = 7'd1; addrs[1] = 7'd2; addrs[2] = 7'd3; addrs[3] = 7'd5;
    bytes[0] = 8'h01; bytes[1] = 8'h02; bytes[2] = 8'h03; bytes[3] = 8'hA5;
    rd_valid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd_addr_in = addrs[k];
      #2;
      chk("b2b_grant", LB'(rd_ready_out), LB'(1));
      if (k >= 2) begin
        chk("b2b_valid", LB'(rd_data_valid_out), LB'(1));
        chk("b2b_data", rd_data_out, pat(bytes[k-2]));
      end
      $display("b2b issue addr %0d granted=%0b", addrs[k], rd_ready_out);
      tick();
    end
    rd_valid_in = 1'b0;
    chk("b2b_data2", rd_data_out, pat(bytes[2]));
    tick();
    chk("b2b_data3", rd_data_out, pat(bytes[3]));
    chk("b2b_valid3", LB'(rd_data_valid_out), LB'(1));
    tick();
    chk("b2b_empty", LB'(rd_data_valid_out), LB'(0));

    // Reset with one entry buffered and one read in flight
    rd_data_ready_in = 1'b0;
    rd_valid_in = 1'b1; rd_addr_in = 7'd1;
    tick();
    rd_addr_in = 7'd2;
    tick();
    rd_valid_in = 1'b0;
    chk("prerst_valid", LB'(rd_data_valid_out), LB'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", LB'(rd_data_valid_out), LB'(0));
    chk("rst_rd_ready", LB'(rd_ready_out), LB'(0));
    tick(); tick();
    rst_n = 1'b1;
    #1 chk("post_rst_valid", LB'(rd_data_valid_out), LB'(0));
    tick();
    chk("post_rst_valid2", LB'(rd_data_valid_out), LB'(0));
    rd_data_ready_in = 1'b1;
    rd_valid_in = 1'b1; rd_addr_in = 7'd3;
    #2 chk("post_rst_grant", LB'(rd_ready_out), LB'(1));
    tick();
    rd_valid_in = 1'b0;
    tick();
    chk("post_rst_data_valid", LB'(rd_data_valid_out), LB'(1));
    chk("post_rst_data", rd_data_out, pat(8'h03));
    $display("post-reset read addr 3 data %0h", rd_data_out[7:0]);
    tick();
    chk("post_rst_empty", LB'(rd_data_valid_out), LB'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
